// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a combinational instruction memory,
// and queues {instr, pc} in a small in-order buffer for decode, with redirect flush.
module fetch_stage #(
    parameter int                    REG_BITS = 32,
    parameter logic [REG_BITS-1:0]   RESET_PC = {REG_BITS{1'b0}},
    parameter int                    DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [REG_BITS-1:0]  imem_A,
    input  logic [REG_BITS-1:0]  imem_RD,
    input  logic                 redirect_valid,
    input  logic [REG_BITS-1:0]  redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_BITS-1:0]  out_instr,
    output logic [REG_BITS-1:0]  out_pc,
    output logic [REG_BITS-1:0]  out_pc_plus4
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0]    PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
    localparam logic [REG_BITS-1:0] PC_STEP  = REG_BITS'(4);
    localparam logic [REG_BITS-1:0] WORD_0   = {REG_BITS{1'b0}};

    logic [REG_BITS-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [REG_BITS-1:0] buf_instr_q [DEPTH];
    logic [REG_BITS-1:0] buf_instr_d [DEPTH];
    logic [REG_BITS-1:0] buf_pc_q    [DEPTH];
    logic [REG_BITS-1:0] buf_pc_d    [DEPTH];

    logic push_s;
    logic pop_s;
    logic redirect_lsb_unused_s;

    // Redirect targets are word aligned; the low byte-offset bits carry no meaning.
    assign redirect_lsb_unused_s = ^redirect_pc[1:0];

    assign imem_A = {2'b00, pc_q[REG_BITS-1:2]};

    // Head is masked during a redirect so decode can never consume a stale entry.
    assign out_valid = (count_q != CNT_ZERO) & ~redirect_valid;
    assign pop_s     = out_valid & out_ready;
    assign push_s    = ~redirect_valid & ((count_q < DEPTH_C) | pop_s);

    // Head presentation, zeroed whenever nothing valid is offered.
    always_comb begin
        out_instr    = WORD_0;
        out_pc       = WORD_0;
        out_pc_plus4 = WORD_0;
        if (out_valid) begin
            out_instr    = buf_instr_q[rd_ptr_q];
            out_pc       = buf_pc_q[rd_ptr_q];
            out_pc_plus4 = buf_pc_q[rd_ptr_q] + PC_STEP;
        end else begin
            out_instr    = WORD_0;
            out_pc       = WORD_0;
            out_pc_plus4 = WORD_0;
        end
    end

    // Next-state for PC, pointers and occupancy; redirect overrides push/pop.
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[REG_BITS-1:2], 2'b00};
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (push_s) begin
                pc_d     = pc_q + PC_STEP;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                pc_d     = pc_q;
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
        end
    end

    // Buffer write: capture the memory word together with the PC that fetched it.
    always_comb begin
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        if (push_s) begin
            buf_instr_d[wr_ptr_q] = imem_RD;
            buf_pc_d[wr_ptr_q]    = pc_q;
        end else begin
            buf_instr_d = buf_instr_q;
            buf_pc_d    = buf_pc_q;
        end
    end

    // State registers with asynchronous reset to the startup condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr_q[i] <= WORD_0;
                buf_pc_q[i]    <= WORD_0;
            end
        end else begin
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 64-word combinational memory model and
// hand-computed expectations for streaming, stall, redirect, wrap and reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_A;
    logic [31:0] imem_RD;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    logic [31:0] mem [64];
    logic        addr_hi_unused;

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .REG_BITS (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_A         (imem_A),
        .imem_RD        (imem_RD),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
    );

    assign imem_RD        = mem[imem_A[5:0]];
    assign addr_hi_unused = ^imem_A[31:6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
        mem[3] = 32'h0030_0193;
        for (int i = 4; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);

        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_pc4", out_pc_plus4, 32'h0);
        chk("rst_imemA", imem_A, 32'h0);

        // Streaming at one instruction per cycle
        rst_n = 1'b1;
        tick();
        chk("s0_valid", {31'h0, out_valid}, 32'h1);
        chk("s0_pc", out_pc, 32'h0);
        chk("s0_instr", out_instr, 32'h0000_0013);
        chk("s0_pc4", out_pc_plus4, 32'h4);
        chk("s0_imemA", imem_A, 32'h1);
        tick();
        chk("s1_pc", out_pc, 32'h4);
        chk("s1_instr", out_instr, 32'h0010_0093);
        chk("s1_pc4", out_pc_plus4, 32'h8);
        tick();
        chk("s2_pc", out_pc, 32'h8);
        chk("s2_instr", out_instr, 32'h0020_0113);
        tick();
        chk("s3_pc", out_pc, 32'hC);
        chk("s3_instr", out_instr, 32'h0030_0193);
        chk("s3_pc4", out_pc_plus4, 32'h10);

        // Stall: buffer fills to two entries and PC holds at 8
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("st_first_pc", out_pc, 32'h0);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("st_hold_instr", out_instr, 32'h0000_0013);
            chk("st_hold_pc", out_pc, 32'h0);
            chk("st_hold_imemA", imem_A, 32'h2);
            chk("st_hold_valid", {31'h0, out_valid}, 32'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("st_rel_pc0", out_pc, 32'h0);
        tick();
        chk("st_rel_pc4", out_pc, 32'h4);
        chk("st_rel_instr4", out_instr, 32'h0010_0093);
        tick();
        chk("st_rel_pc8", out_pc, 32'h8);
        chk("st_rel_instr8", out_instr, 32'h0020_0113);

        // Redirect with two entries buffered
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        chk("rd_mask_valid", {31'h0, out_valid}, 32'h0);
        chk("rd_mask_pc", out_pc, 32'h0);
        chk("rd_mask_instr", out_instr, 32'h0);
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        chk("rd_gap_valid", {31'h0, out_valid}, 32'h0);
        chk("rd_gap_imemA", imem_A, 32'h10);
        tick();
        chk("rd_new_valid", {31'h0, out_valid}, 32'h1);
        chk("rd_new_pc", out_pc, 32'h40);
        chk("rd_new_instr", out_instr, 32'hC0DE_0010);
        chk("rd_new_pc4", out_pc_plus4, 32'h44);

        // Unaligned redirect target is forced to a word boundary
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        #1;
        chk("ua_mask_valid", {31'h0, out_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("ua_imemA", imem_A, 32'h10);
        tick();
        chk("ua_pc", out_pc, 32'h40);
        chk("ua_instr", out_instr, 32'hC0DE_0010);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wr_imemA", imem_A, 32'h3FFF_FFFF);
        tick();
        chk("wr_pc", out_pc, 32'hFFFF_FFFC);
        chk("wr_pc4", out_pc_plus4, 32'h0);
        chk("wr_instr", out_instr, 32'hC0DE_003F);
        tick();
        chk("wr_next_pc", out_pc, 32'h0);
        chk("wr_next_instr", out_instr, 32'h0000_0013);
        chk("wr_next_pc4", out_pc_plus4, 32'h4);

        // Back-to-back redirects: the later target wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_pc = 32'h20;
        #1;
        chk("bb_mask_valid", {31'h0, out_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("bb_imemA", imem_A, 32'h8);
        tick();
        chk("bb_pc", out_pc, 32'h20);
        chk("bb_instr", out_instr, 32'hC0DE_0008);

        // Asynchronous reset while the buffer is full
        out_ready = 1'b0;
        tick();
        tick();
        chk("ar_full_valid", {31'h0, out_valid}, 32'h1);
        chk("ar_full_pc", out_pc, 32'h20);
        chk("ar_full_imemA", imem_A, 32'hA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'h0, out_valid}, 32'h0);
        chk("ar_imemA", imem_A, 32'h0);
        chk("ar_pc", out_pc, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_restart_pc", out_pc, 32'h0);
        chk("ar_restart_instr", out_instr, 32'h0000_0013);
        out_ready = 1'b1;
        tick();
        chk("ar_next_pc", out_pc, 32'h4);
        chk("ar_next_instr", out_instr, 32'h0010_0093);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
